// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: walks two parallel operands LSB-first through an
// external single-bit full-adder slice over a req/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_req,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  input  logic             fa_done
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_FIN
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic               carry_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;
  logic               fa_req_q;
  logic               fa_a_q;
  logic               fa_b_q;
  logic               fa_cin_q;
  logic               last_bit;

  assign idx_d    = idx_q + IDX_W'(1);
  assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

  // Slice-facing outputs are registered so a combinational fa_done never loops back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fa_req_q <= 1'b0;
      fa_a_q   <= 1'b0;
      fa_b_q   <= 1'b0;
      fa_cin_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            carry_q  <= cin;
            idx_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b1;
            fa_req_q <= 1'b1;
            fa_a_q   <= op_a[0];
            fa_b_q   <= op_b[0];
            fa_cin_q <= cin;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (fa_done) begin
            sum_q[idx_q] <= fa_sum;
            carry_q      <= fa_cout;
            fa_req_q     <= 1'b0;
            fa_a_q       <= 1'b0;
            fa_b_q       <= 1'b0;
            fa_cin_q     <= 1'b0;
            if (last_bit) begin
              cout_q  <= fa_cout;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              idx_q   <= idx_d;
              state_q <= S_GAP;
            end
          end
        end
        // Return-to-zero cycle so the slice always sees a fresh request edge.
        S_GAP: begin
          fa_req_q <= 1'b1;
          fa_a_q   <= a_q[idx_q];
          fa_b_q   <= b_q[idx_q];
          fa_cin_q <= carry_q;
          state_q  <= S_REQ;
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = sum_q;
  assign cout   = cout_q;
  assign fa_req = fa_req_q;
  assign fa_a   = fa_a_q;
  assign fa_b   = fa_b_q;
  assign fa_cin = fa_cin_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural full-adder slice
// whose fa_done delay is selectable per operation.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       fa_req;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_sum;
  logic       fa_cout;
  logic       fa_done;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural slice
  int dly_sel = 0;
  int wcnt    = 0;
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_done = fa_req && (wcnt >= dly_sel);

  always @(posedge clk) begin
    if (fa_req && !fa_done) wcnt <= wcnt + 1;
    else                    wcnt <= 0;
  end

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .fa_req  (fa_req),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout),
    .fa_done (fa_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // monitor model of the operation in flight
  logic       mon_en  = 1'b0;
  logic [7:0] exp_a   = '0;
  logic [7:0] exp_b   = '0;
  logic       carry_m = 1'b0;
  int         bit_cnt = 0;
  int         req_hi  = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if (fa_req) begin
        chk("fa_a_bit",   {31'd0, fa_a},   {31'd0, exp_a[bit_cnt]});
        chk("fa_b_bit",   {31'd0, fa_b},   {31'd0, exp_b[bit_cnt]});
        chk("fa_cin_bit", {31'd0, fa_cin}, {31'd0, carry_m});
        req_hi++;
        if (fa_done) begin
          carry_m = (exp_a[bit_cnt] & exp_b[bit_cnt]) | (exp_a[bit_cnt] & carry_m)
                  | (exp_b[bit_cnt] & carry_m);
          bit_cnt++;
        end
      end else begin
        chk("fa_idle_zero", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      end
    end
  end

  task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic ci, input int dly);
    op_a     = a;
    op_b     = b;
    cin      = ci;
    start    = 1'b1;
    dly_sel  = dly;
    exp_a    = a;
    exp_b    = b;
    carry_m  = ci;
    bit_cnt  = 0;
    req_hi   = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
  endtask

  // waits (bounded) for done, counting cycles from c0
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input int dly, input logic [7:0] er,
                        input logic ec, input int elat);
    int cyc;
    do_start(a, b, ci, dly);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    wait_done(0, cyc);
    chk({tag, "_latency"}, cyc, elat);
    chk({tag, "_result"}, {24'd0, result}, {24'd0, er});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_req_cycles"}, req_hi, 8 * (dly + 1));
    chk({tag, "_result_hold"}, {24'd0, result}, {24'd0, er});
  endtask

  initial begin
    int cyc;
    int spurious;
    rst_n = 1'b0;
    start = 1'b1;
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    cin   = 1'b1;

    // reset held for two edges with start asserted
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {17'd0, busy, done, result, cout, fa_req, fa_a, fa_b, fa_cin}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", {30'd0, busy, fa_req}, 32'd0);
    end

    run_op("basic",   8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0, 15);
    op_a = 8'hAA;
    op_b = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_result", {23'd0, result, cout}, {23'd0, 8'h10, 1'b0});

    run_op("ovf1",    8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 15);
    run_op("ovf2",    8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 15);
    run_op("cin_only",8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0, 15);
    run_op("waits",   8'hA5, 8'h3C, 1'b0, 3, 8'hE1, 1'b0, 39);

    // start while busy is ignored
    do_start(8'h10, 8'h20, 1'b0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, cyc);
    chk("busy_start_latency", cyc, 15);
    chk("busy_start_result", {23'd0, result, cout}, {23'd0, 8'h30, 1'b0});
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) spurious++;
    end
    chk("busy_start_single_op", spurious, 0);
    chk("busy_start_done_count", done_cnt, 1);

    // reset in the middle of an operation (idx = 4)
    do_start(8'h33, 8'h44, 1'b0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("midop_in_req", {31'd0, fa_req}, 32'd1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    chk("midop_reset_outputs", {17'd0, busy, done, result, cout, fa_req, fa_a, fa_b, fa_cin}, 32'd0);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy || fa_req) spurious++;
    end
    chk("midop_no_done", spurious, 0);

    run_op("after_rst", 8'h55, 8'hAA, 1'b1, 0, 8'h00, 1'b1, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add controller that drives a single-bit full-adder slice (inputs a/b/c_in, outputs sum/c_out/done) to compute an N-bit sum LSB-first. It accepts parallel operands on a start strobe and presents one bit per request to the slice over a req/done handshake. It feeds each returned carry back into the next bit, then reports the full-width result with a one-cycle done pulse. It is the initiator side of the full-adder slice interface.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  launch request; sampled only in IDLE
- op_a  in  WIDTH  operand A, captured on accepted start
- op_b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in, captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result/cout valid
- result  out  WIDTH  (op_a+op_b+cin) mod 2^WIDTH
- cout  out  1  final carry out
- fa_req  out  1  request to slice; fa_a/fa_b/fa_cin valid while high
- fa_a  out  1  op_a bit under evaluation
- fa_b  out  1  op_b bit under evaluation
- fa_cin  out  1  running carry
- fa_sum  in  1  slice sum; sampled when fa_done=1 in REQ
- fa_cout  in  1  slice carry; sampled when fa_done=1 in REQ
- fa_done  in  1  slice completion; level, may be combinational from fa_req

## Operation

- States: IDLE, REQ, GAP, FIN.
- IDLE: busy=0. start=1 → latch op_a, op_b, carry←cin, idx←0, result shift register←0; next state REQ.
- REQ: fa_req=1, fa_a=a_reg[idx], fa_b=b_reg[idx], fa_cin=carry. Remain in REQ while fa_done=0.
- REQ with fa_done=1: result[idx]←fa_sum, carry←fa_cout. If idx=WIDTH-1, go to FIN. Otherwise idx←idx+1 and go to GAP.
- GAP: fa_req=0 for exactly one cycle (return-to-zero so the slice sees a fresh req edge); next state REQ.
- FIN: done=1, cout=carry, result fully updated; next state IDLE.
- fa_a/fa_b/fa_cin are 0 outside REQ. They are stable for the whole REQ dwell.
- result/cout hold their values from FIN until the next accepted start. They do not clear on done.
- start outside IDLE (including the FIN cycle) is ignored and has no side effects.
- fa_done outside REQ is ignored.
- idx width is clog2(WIDTH). There is no wrap-around: the FIN transition is taken at idx=WIDTH-1.

## Timing

- Reset (rst_n=0 at a rising edge): state←IDLE; busy, done, result, cout, fa_req, fa_a, fa_b, fa_cin all 0 from the following cycle.
- Reset during any state aborts the operation. No done is issued and the partial result is discarded.
- Zero-wait slice (fa_done=fa_req): edge E0 accepts start. Bit i is sampled at edge E0+2i+1. done is high in the cycle after edge E0+2·WIDTH-1, i.e. latency 2·WIDTH-1 cycles (15 for WIDTH=8).
- Each cycle fa_done stays low in REQ adds one cycle of latency.
- Earliest next start: the cycle after FIN, once back in IDLE. Back-to-back throughput is one operation per 2·WIDTH+1 cycles with a zero-wait slice.
- busy rises the cycle after start is accepted and falls the cycle after done.

## Test plan

- Reset: hold rst_n=0 for 2 edges with start=1 → all outputs 0 and busy=0; release → IDLE, no spurious fa_req.
- Basic add, zero-wait behavioural slice, WIDTH=8: op_a=8'h0F, op_b=8'h01, cin=0 → result=8'h10, cout=0, single done pulse exactly 15 cycles after the start edge; fa_req toggles 1/0 with 8 high cycles.
- Carry/overflow: 8'hFF+8'h01, cin=0 → result=8'h00, cout=1. Then 8'hFF+8'hFF, cin=1 → result=8'hFF, cout=1. Then 8'h00+8'h00, cin=1 → result=8'h01, cout=0.
- Wait states: slice asserts fa_done 3 cycles after each fa_req rise, op_a=8'hA5, op_b=8'h3C, cin=0 → result=8'hE1, cout=0, latency 15+24=39 cycles; fa_a/fa_b/fa_cin unchanged throughout each REQ dwell.
- Start while busy: start 8'h10+8'h20, then start 8'hFF+8'hFF at cycle 5 → exactly one done with result=8'h30, cout=0; second start has no effect.
- Reset mid-op: deassert rst_n while idx=4 → outputs 0 next cycle, no done. Then start 8'h55+8'hAA, cin=1 → result=8'h00, cout=1.
